// File: rtl/demux_scheduler.sv
// Round-robin burst scheduler driving a 1x4 transmission-gate demux.
// Inserts a settle gap whenever the select lines move so no live data crosses a switching gate.
module demux_scheduler #(
    parameter int BURST  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [3:0] ch_ready,
    output logic [1:0] sel,
    output logic       dmx_in,
    output logic [3:0] ch_valid,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_XFER} state_t;

    localparam logic [4:0] LAST_BEAT = 5'(BURST - 1);
    localparam logic [2:0] WAIT_INIT = 3'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t     state;
    logic [1:0] last;
    logic [4:0] beat;
    logic [2:0] waitcnt;
    logic [1:0] grant;
    logic [1:0] cand;
    logic       found;

    // First ready channel after the previous owner wins; the previous owner is tried last.
    always_comb begin
        grant = last;
        cand  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && ch_ready[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign in_ready = (state == S_XFER) && ch_ready[sel];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sel      <= 2'b00;
            dmx_in   <= 1'b0;
            ch_valid <= 4'b0000;
            last     <= 2'b11;
            beat     <= 5'd0;
            waitcnt  <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    ch_valid <= 4'b0000;
                    if (in_valid && (ch_ready != 4'b0000)) begin
                        sel  <= grant;
                        beat <= 5'd0;
                        if ((grant == sel) || (SETTLE == 0)) begin
                            state <= S_XFER;
                        end else begin
                            dmx_in  <= 1'b0;
                            waitcnt <= WAIT_INIT;
                            state   <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    ch_valid <= 4'b0000;
                    dmx_in   <= 1'b0;
                    if (waitcnt == 3'd0) begin
                        state <= S_XFER;
                    end else begin
                        waitcnt <= waitcnt - 3'd1;
                    end
                end
                S_XFER: begin
                    // A sink dropping ready releases the grant even if upstream is offering a bit.
                    if (!ch_ready[sel]) begin
                        ch_valid <= 4'b0000;
                        last     <= sel;
                        state    <= S_IDLE;
                    end else if (in_valid) begin
                        dmx_in   <= in_data;
                        ch_valid <= 4'(4'b0001 << sel);
                        beat     <= beat + 5'd1;
                        if (beat == LAST_BEAT) begin
                            last  <= sel;
                            state <= S_IDLE;
                        end
                    end else begin
                        ch_valid <= 4'b0000;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: instance A uses BURST=4, instance B uses BURST=2.
// Both share stimulus; each scenario checks the instance whose burst length it targets.
module tb_demux_scheduler;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inData;
    logic [3:0] chReady;

    logic       irA, dmxA, busyA;
    logic [1:0] selA;
    logic [3:0] chvA;
    logic       irB, dmxB, busyB;
    logic [1:0] selB;
    logic [3:0] chvB;

    int vecCount  = 0;
    int missCount = 0;

    demux_scheduler #(.BURST(4), .SETTLE(1)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(irA),
        .ch_ready(chReady), .sel(selA), .dmx_in(dmxA), .ch_valid(chvA), .busy(busyA)
    );

    demux_scheduler #(.BURST(2), .SETTLE(1)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(irB),
        .ch_ready(chReady), .sel(selB), .dmx_in(dmxB), .ch_valid(chvB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic [3:0] r);
        inValid = v;
        inData  = d;
        chReady = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDuts();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inValid = 1'b0;
        inData  = 1'b0;
        chReady = 4'b0000;

        // Reset asserted before any clock edge
        #3;
        checkOutput("rst_sel",  8'(selA),  8'h0);
        checkOutput("rst_dmx",  8'(dmxA),  8'h0);
        checkOutput("rst_chv",  8'(chvA),  8'h0);
        checkOutput("rst_ir",   8'(irA),   8'h0);
        checkOutput("rst_busy", 8'(busyA), 8'h0);
        resetDuts();

        $display("[TB] single channel, same select");
        applyStimulus(1'b1, 1'b1, 4'b0001);
        step();
        checkOutput("s1_sel",  8'(selA),  8'h0);
        checkOutput("s1_busy", 8'(busyA), 8'h1);
        checkOutput("s1_ir",   8'(irA),   8'h1);
        checkOutput("s1_chv0", 8'(chvA),  8'h0);
        step();
        checkOutput("s1_b0_chv", 8'(chvA), 8'h1);
        checkOutput("s1_b0_dmx", 8'(dmxA), 8'h1);
        applyStimulus(1'b1, 1'b0, 4'b0001);
        step();
        checkOutput("s1_b1_chv", 8'(chvA), 8'h1);
        checkOutput("s1_b1_dmx", 8'(dmxA), 8'h0);
        applyStimulus(1'b1, 1'b1, 4'b0001);
        step();
        checkOutput("s1_b2_chv", 8'(chvA), 8'h1);
        checkOutput("s1_b2_dmx", 8'(dmxA), 8'h1);
        step();
        checkOutput("s1_b3_chv",  8'(chvA),  8'h1);
        checkOutput("s1_b3_dmx",  8'(dmxA),  8'h1);
        checkOutput("s1_b3_busy", 8'(busyA), 8'h0);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        step();
        checkOutput("s1_end_chv",  8'(chvA),  8'h0);
        checkOutput("s1_end_busy", 8'(busyA), 8'h0);
        checkOutput("s1_end_ir",   8'(irA),   8'h0);
        resetDuts();

        $display("[TB] round-robin rotation, BURST=2");
        applyStimulus(1'b1, 1'b1, 4'b1111);
        step();
        checkOutput("rr_first_sel", 8'(selB), 8'h0);
        checkOutput("rr_first_ir",  8'(irB),  8'h1);
        step();
        checkOutput("rr_c0_p0", 8'(chvB), 8'h1);
        step();
        checkOutput("rr_c0_p1",   8'(chvB),  8'h1);
        checkOutput("rr_c0_busy", 8'(busyB), 8'h0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ch;
            logic [3:0] oh;
            ch = 2'(k + 1);
            oh = 4'(4'b0001 << ch);
            step();
            checkOutput($sformatf("rr_c%0d_settle_sel", ch), 8'(selB), 8'(ch));
            checkOutput($sformatf("rr_c%0d_settle_chv", ch), 8'(chvB), 8'h0);
            checkOutput($sformatf("rr_c%0d_settle_dmx", ch), 8'(dmxB), 8'h0);
            checkOutput($sformatf("rr_c%0d_settle_ir",  ch), 8'(irB),  8'h0);
            step();
            checkOutput($sformatf("rr_c%0d_xfer_chv", ch), 8'(chvB), 8'h0);
            checkOutput($sformatf("rr_c%0d_xfer_ir",  ch), 8'(irB),  8'h1);
            step();
            checkOutput($sformatf("rr_c%0d_p0", ch), 8'(chvB), 8'(oh));
            checkOutput($sformatf("rr_c%0d_d0", ch), 8'(dmxB), 8'h1);
            step();
            checkOutput($sformatf("rr_c%0d_p1",   ch), 8'(chvB),  8'(oh));
            checkOutput($sformatf("rr_c%0d_busy", ch), 8'(busyB), 8'h0);
        end
        resetDuts();

        $display("[TB] early release on channel 2");
        applyStimulus(1'b1, 1'b1, 4'b0100);
        step();
        checkOutput("er_settle_sel", 8'(selA), 8'h2);
        checkOutput("er_settle_ir",  8'(irA),  8'h0);
        step();
        checkOutput("er_xfer_ir", 8'(irA), 8'h1);
        step();
        checkOutput("er_p0", 8'(chvA), 8'h4);
        step();
        checkOutput("er_p1", 8'(chvA), 8'h4);
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkOutput("er_ir_drop", 8'(irA), 8'h0);
        step();
        checkOutput("er_no_p2",  8'(chvA),  8'h0);
        checkOutput("er_idle",   8'(busyA), 8'h0);
        applyStimulus(1'b1, 1'b1, 4'b1100);
        step();
        checkOutput("er_next_sel",  8'(selA),  8'h3);
        checkOutput("er_next_busy", 8'(busyA), 8'h1);
        resetDuts();

        $display("[TB] upstream stall mid-burst");
        applyStimulus(1'b1, 1'b1, 4'b0001);
        step();
        step();
        checkOutput("st_p0", 8'(chvA), 8'h1);
        step();
        checkOutput("st_p1", 8'(chvA), 8'h1);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("st_gap%0d_chv",  k), 8'(chvA),  8'h0);
            checkOutput($sformatf("st_gap%0d_sel",  k), 8'(selA),  8'h0);
            checkOutput($sformatf("st_gap%0d_busy", k), 8'(busyA), 8'h1);
        end
        applyStimulus(1'b1, 1'b0, 4'b0001);
        step();
        checkOutput("st_p2",     8'(chvA), 8'h1);
        checkOutput("st_p2_dmx", 8'(dmxA), 8'h0);
        step();
        checkOutput("st_p3",      8'(chvA),  8'h1);
        checkOutput("st_p3_busy", 8'(busyA), 8'h0);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        step();
        checkOutput("st_after_chv", 8'(chvA), 8'h0);
        resetDuts();

        $display("[TB] asynchronous reset mid-burst");
        applyStimulus(1'b1, 1'b1, 4'b0100);
        step();
        step();
        step();
        checkOutput("mr_p0",  8'(chvA), 8'h4);
        checkOutput("mr_dmx", 8'(dmxA), 8'h1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'b1111);
        checkOutput("mr_sel",  8'(selA),  8'h0);
        checkOutput("mr_dmx0", 8'(dmxA),  8'h0);
        checkOutput("mr_chv",  8'(chvA),  8'h0);
        checkOutput("mr_ir",   8'(irA),   8'h0);
        checkOutput("mr_busy", 8'(busyA), 8'h0);
        rst = 1'b0;
        #1;
        step();
        checkOutput("mr_grant_sel",  8'(selA),  8'h0);
        checkOutput("mr_grant_busy", 8'(busyA), 8'h1);
        checkOutput("mr_grant_ir",   8'(irA),   8'h1);
        step();
        checkOutput("mr_grant_p0", 8'(chvA), 8'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
